// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the fetch address, resolves next-PC from
// sequential/branch/jump/jr sources, and tracks halt, misaligned jr and commits.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] SignExtImm,
    input  logic [25:0] JumpIndex,
    input  logic [31:0] RegTarget,
    input  logic        Branch,
    input  logic        BranchCond,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic        Halt,
    input  logic        Stall,
    input  logic        ImemReady,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] BranchTarget,
    output logic        InstrValid,
    output logic        Halted,
    output logic        Misaligned,
    output logic [31:0] InstrCount
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    logic        commit;
    logic [31:0] next_pc;

    // Word offset scaled to bytes; the two bits shifted out of the top are lost.
    function automatic logic [31:0] branch_dest(input logic [31:0]        base,
                                                input logic signed [31:0] imm);
        logic signed [31:0] off;
        off = imm <<< 2;
        return base + $unsigned(off);
    endfunction

    function automatic logic [31:0] jump_dest(input logic [31:0] base,
                                              input logic [25:0] index);
        return {base[31:28], index, 2'b00};
    endfunction

    assign PCPlus4      = PC + 32'd4;
    assign BranchTarget = branch_dest(PCPlus4, SignExtImm);
    assign InstrValid   = (state == RUN) && ImemReady;
    assign commit       = InstrValid && !Stall;

    always_comb begin
        next_pc = PCPlus4;
        if (JumpReg)
            next_pc = {RegTarget[31:2], 2'b00};
        else if (Jump)
            next_pc = jump_dest(PCPlus4, JumpIndex);
        else if (Branch && BranchCond)
            next_pc = BranchTarget;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= BOOT;
            PC         <= RESET_PC;
            InstrCount <= 32'd0;
            Misaligned <= 1'b0;
            Halted     <= 1'b0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (commit) begin
                        InstrCount <= InstrCount + 32'd1;
                        if (Halt) begin
                            // Halt wins over any redirect; PC keeps the halt address.
                            state  <= HALT;
                            Halted <= 1'b1;
                        end else begin
                            PC <= next_pc;
                            if (JumpReg && (RegTarget[1:0] != 2'b00))
                                Misaligned <= 1'b1;
                        end
                    end
                end
                HALT:    state <= HALT;
                default: state <= BOOT;
            endcase
        end
    end

endmodule
